joy_answer_arbiter: RTL and testbench



---
 rtl/joy_answer_arbiter.sv | 155 +++++++++++++++
 tb/tb_joy_answer_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_answer_arbiter.sv
// Two-player quiz input stage: sync, debounce, one-hot check, first-answer arbitration with lockout.
// Answer/invalid events are registered pulses; a clean press reports DEBOUNCE_CYCLES+3 edges after first sampling.
module joy_answer_arbiter #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] joy_left,
  input  logic [8:0] joy_right,
  input  logic       lock_clear,
  output logic       ans_valid,
  output logic       ans_player,
  output logic [8:0] ans_code,
  output logic       locked,
  output logic       invalid_left,
  output logic       invalid_right
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic { RELEASED = 1'b0, HELD   = 1'b1 } pstate_e;
  typedef enum logic { ARMED    = 1'b0, LOCKED = 1'b1 } astate_e;

  logic [1:0][8:0] joy_raw;
  logic [1:0]      press_vld;
  logic [1:0]      press_bad;
  logic [1:0][8:0] press_dat;

  assign joy_raw = {joy_right, joy_left};

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [8:0]    sync1_q, sync2_q;
    logic [8:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    pstate_e       state_q, state_d;
    logic          zero_seen_q, zero_seen_d;
    logic          stable, onehot, press;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q     <= '0;
        sync2_q     <= '0;
        cand_q      <= '0;
        cnt_q       <= '0;
        state_q     <= RELEASED;
        zero_seen_q <= 1'b0;
      end else begin
        sync1_q     <= joy_raw[p];
        sync2_q     <= sync1_q;
        cand_q      <= cand_d;
        cnt_q       <= cnt_d;
        state_q     <= state_d;
        zero_seen_q <= zero_seen_d;
      end
    end

    always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    assign stable = (cnt_q == CNT_MAX);
    assign onehot = (cand_q != '0) && ((cand_q & (cand_q - 9'd1)) == '0);

    // A press only counts once the stick has been seen stably released since
    // reset, so a button held across reset cannot fire on its own.
    always_comb begin
      state_d     = state_q;
      zero_seen_d = zero_seen_q;
      press       = 1'b0;
      if (stable) begin
        if (cand_q == '0) begin
          zero_seen_d = 1'b1;
        end
        if (state_q == RELEASED) begin
          if (cand_q != '0) begin
            state_d = HELD;
            press   = zero_seen_q;
          end
        end else if (cand_q == '0) begin
          state_d = RELEASED;
        end
      end
    end

    assign press_vld[p] = press & onehot;
    assign press_bad[p] = press & ~onehot;
    assign press_dat[p] = cand_q;
  end

  astate_e    astate_q, astate_d;
  logic       tie_q, tie_d;
  logic       ans_valid_q, ans_valid_d;
  logic       ans_player_q, ans_player_d;
  logic [8:0] ans_code_q, ans_code_d;
  logic [1:0] invalid_q;
  logic       winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      astate_q     <= ARMED;
      tie_q        <= 1'b0;
      ans_valid_q  <= 1'b0;
      ans_player_q <= 1'b0;
      ans_code_q   <= '0;
      invalid_q    <= '0;
    end else begin
      astate_q     <= astate_d;
      tie_q        <= tie_d;
      ans_valid_q  <= ans_valid_d;
      ans_player_q <= ans_player_d;
      ans_code_q   <= ans_code_d;
      invalid_q    <= press_bad;
    end
  end

  // Presses arriving while locked (even alongside lock_clear) are dropped.
  always_comb begin
    astate_d     = astate_q;
    tie_d        = tie_q;
    ans_valid_d  = 1'b0;
    ans_player_d = ans_player_q;
    ans_code_d   = ans_code_q;
    winner       = press_vld[1];
    if (astate_q == ARMED) begin
      if (press_vld != 2'b00) begin
        if (press_vld == 2'b11) begin
          winner = tie_q;
          tie_d  = ~tie_q;
        end
        ans_valid_d  = 1'b1;
        ans_player_d = winner;
        ans_code_d   = press_dat[winner];
        astate_d     = LOCKED;
      end
    end else if (lock_clear) begin
      astate_d = ARMED;
    end
  end

  assign ans_valid     = ans_valid_q;
  assign ans_player    = ans_player_q;
  assign ans_code      = ans_code_q;
  assign locked        = (astate_q == LOCKED);
  assign invalid_left  = invalid_q[0];
  assign invalid_right = invalid_q[1];

endmodule

// File: tb/tb_joy_answer_arbiter.sv
// Scoreboard bench for joy_answer_arbiter with DEBOUNCE_CYCLES = 4.
module tb_joy_answer_arbiter;

  localparam int DC  = 4;
  localparam int LAT = DC + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] joy_left, joy_right;
  logic       lock_clear;
  logic       ans_valid, ans_player, locked, invalid_left, invalid_right;
  logic [8:0] ans_code;

  joy_answer_arbiter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .joy_left(joy_left), .joy_right(joy_right),
    .lock_clear(lock_clear), .ans_valid(ans_valid), .ans_player(ans_player),
    .ans_code(ans_code), .locked(locked), .invalid_left(invalid_left),
    .invalid_right(invalid_right)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       player;
    logic [8:0] code;
    int         cyc;
  } exp_t;

  exp_t ans_q[$];
  exp_t inv_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard side: every observed event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ans_valid) begin
        if (ans_q.size() == 0) begin
          chk("spurious_ans", {31'd0, ans_valid}, 32'd0);
        end else begin
          exp_t e;
          e = ans_q.pop_front();
          chk("ans_player", {31'd0, ans_player}, {31'd0, e.player});
          chk("ans_code", {23'd0, ans_code}, {23'd0, e.code});
          chk("ans_cycle", cyc, e.cyc);
          chk("locked_with_ans", {31'd0, locked}, 32'd1);
        end
      end
      for (int s = 0; s < 2; s++) begin
        logic pulse;
        pulse = (s == 0) ? invalid_left : invalid_right;
        if (pulse) begin
          if (inv_q.size() == 0) begin
            chk("spurious_inv", {31'd0, pulse}, 32'd0);
          end else begin
            exp_t e;
            e = inv_q.pop_front();
            chk("inv_side", s, {31'd0, e.player});
            chk("inv_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expect_ans(input logic player, input logic [8:0] code);
    exp_t e;
    e.player = player; e.code = code; e.cyc = cyc + LAT;
    ans_q.push_back(e);
  endtask

  task automatic expect_inv(input logic player);
    exp_t e;
    e.player = player; e.code = '0; e.cyc = cyc + LAT;
    inv_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && (ans_q.size() != 0 || inv_q.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    chk(tag, ans_q.size() + inv_q.size(), 32'd0);
  endtask

  task automatic clear_lock();
    lock_clear = 1'b1;
    @(negedge clk);
    lock_clear = 1'b0;
    chk("locked_after_clear", {31'd0, locked}, 32'd0);
  endtask

  task automatic release_and_clear();
    joy_left = '0; joy_right = '0;
    wait_cyc(10);
    clear_lock();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; joy_left = '0; joy_right = '0; lock_clear = 1'b0;
    wait_cyc(3);
    chk("rst_ans_valid", {31'd0, ans_valid}, 32'd0);
    chk("rst_ans_player", {31'd0, ans_player}, 32'd0);
    chk("rst_ans_code", {23'd0, ans_code}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_inv_l", {31'd0, invalid_left}, 32'd0);
    chk("rst_inv_r", {31'd0, invalid_right}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Clean left press.
    joy_left = 9'b000001000;
    expect_ans(1'b0, 9'b000001000);
    drain("t1_drain");
    chk("t1_locked", {31'd0, locked}, 32'd1);
    release_and_clear();
    chk("t1_code_holds", {23'd0, ans_code}, {23'd0, 9'b000001000});

    // Right bounces every 2 cycles, then settles.
    for (int i = 0; i < 10; i++) begin
      joy_right = (i % 2 == 0) ? 9'b000100000 : 9'b0;
      wait_cyc(2);
    end
    joy_right = 9'b000100000;
    expect_ans(1'b1, 9'b000100000);
    drain("t2_drain");
    release_and_clear();

    // Two simultaneous presses: tie priority alternates.
    joy_left = 9'b000000001; joy_right = 9'b100000000;
    expect_ans(1'b0, 9'b000000001);
    drain("t3a_drain");
    release_and_clear();
    joy_left = 9'b000000001; joy_right = 9'b100000000;
    expect_ans(1'b1, 9'b100000000);
    drain("t3b_drain");
    release_and_clear();

    // Press held through the lock cannot fire after re-arm.
    joy_left = 9'b000010000;
    expect_ans(1'b0, 9'b000010000);
    drain("t4a_drain");
    joy_right = 9'b000000010;
    wait_cyc(12);
    chk("t4_still_locked", {31'd0, locked}, 32'd1);
    clear_lock();
    wait_cyc(15);
    chk("t4_no_refire", ans_q.size(), 32'd0);
    joy_right = '0;
    wait_cyc(10);
    joy_right = 9'b000000010;
    expect_ans(1'b1, 9'b000000010);
    drain("t4b_drain");
    release_and_clear();

    // Multi-hot press flagged; a change while held stays silent.
    joy_left = 9'b000000011;
    expect_inv(1'b0);
    drain("t5a_drain");
    joy_left = 9'b000000001;
    wait_cyc(15);
    chk("t5_no_event_locked", {31'd0, locked}, 32'd0);
    joy_left = '0;
    wait_cyc(10);
    joy_left = 9'b000000001;
    expect_ans(1'b0, 9'b000000001);
    drain("t5b_drain");

    // Invalid still reported while locked.
    joy_right = 9'b011000000;
    expect_inv(1'b1);
    drain("t5c_drain");
    release_and_clear();

    // Reset during lock with left held.
    joy_left = 9'b100000000;
    expect_ans(1'b0, 9'b100000000);
    drain("t6a_drain");
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_locked", {31'd0, locked}, 32'd0);
    chk("t6_rst_code", {23'd0, ans_code}, 32'd0);
    chk("t6_rst_valid", {31'd0, ans_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("t6_no_fire_held", {31'd0, locked}, 32'd0);
    joy_left = '0;
    wait_cyc(10);
    joy_left = 9'b100000000;
    expect_ans(1'b0, 9'b100000000);
    drain("t6b_drain");
    release_and_clear();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
